// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the byte-serial FP multiplier front end.
package fp_mult_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, COLLECT, GAP} state_t;

  localparam logic [63:0] QNAN64        = 64'h7FF8_0000_0000_0000;
  localparam int          OPERAND_BYTES = 16;
  localparam int          RESULT_BYTES  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);

  logic [N-1:0]   hit;
  logic [IDW-1:0] cand [N];

  // cand[gi] is the requester sitting gi positions after the pointer
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IDW:0] sum;
    assign sum      = {1'b0, ptr} + (IDW+1)'(gi);
    assign cand[gi] = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
    assign hit[gi]  = req[cand[gi]];
  end

  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
    if (en && (|hit)) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one byte-serial double multiplier among N requesters: round-robin grant,
// 16-byte operand stream out, 8-byte result collected and returned with its owner ID.
module fp_mult_arbiter
  import fp_mult_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDW     = $clog2(N),
  parameter int TIMEOUT = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N-1:0]    REQ_VALID,
  input  logic [64*N-1:0] REQ_A,
  input  logic [64*N-1:0] REQ_B,
  output logic [N-1:0]    REQ_READY,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [IDW-1:0]  RSP_ID,
  output logic [63:0]     RSP_DATA,
  output logic            RSP_ERR,
  output logic            MUL_RESET,
  output logic            MUL_ENABLE,
  output logic [7:0]      MUL_DATA,
  input  logic            MUL_READY,
  input  logic [7:0]      MUL_RESULT,
  output logic            BUSY
);

  state_t         state_reg;
  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW-1:0] id_reg;
  logic [127:0]   shreg_reg;
  logic [3:0]     load_cnt_reg;
  logic [5:0]     tmo_cnt_reg;
  logic [63:0]    res_reg;
  logic [2:0]     res_cnt_reg;
  logic [63:0]    rsp_data_reg;
  logic           rsp_valid_reg;
  logic           rsp_err_reg;
  logic           mul_enable_reg;
  logic [7:0]     mul_data_reg;
  logic           tmo_pulse_reg;

  logic [63:0] op_a [N];
  logic [63:0] op_b [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign op_a[gi] = REQ_A[64*gi +: 64];
    assign op_b[gi] = REQ_B[64*gi +: 64];
  end

  logic           arb_en;
  logic [N-1:0]   arb_gnt;
  logic [IDW-1:0] arb_idx;
  logic           grant_fire;
  logic [IDW-1:0] ptr_next;

  // The one-entry result buffer must be empty before a new operation starts
  assign arb_en = (state_reg == IDLE) && !rsp_valid_reg;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req (REQ_VALID),
    .ptr (rr_ptr_reg),
    .en  (arb_en),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign grant_fire = |arb_gnt;
  assign ptr_next   = (arb_idx == IDW'(N - 1)) ? '0 : arb_idx + 1'b1;

  assign REQ_READY  = arb_gnt;
  assign RSP_VALID  = rsp_valid_reg;
  assign RSP_ID     = id_reg;
  assign RSP_DATA   = rsp_data_reg;
  assign RSP_ERR    = rsp_err_reg;
  assign MUL_ENABLE = mul_enable_reg;
  assign MUL_DATA   = mul_data_reg;
  assign MUL_RESET  = RESET | tmo_pulse_reg;
  assign BUSY       = (state_reg != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      id_reg         <= '0;
      shreg_reg      <= '0;
      load_cnt_reg   <= '0;
      tmo_cnt_reg    <= '0;
      res_reg        <= '0;
      res_cnt_reg    <= '0;
      rsp_data_reg   <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_err_reg    <= 1'b0;
      mul_enable_reg <= 1'b0;
      mul_data_reg   <= '0;
      tmo_pulse_reg  <= 1'b0;
    end else begin
      tmo_pulse_reg <= 1'b0;
      if (rsp_valid_reg && RSP_READY) rsp_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            // Byte 0 goes out on the grant edge; the rest follow from the shifter
            mul_data_reg   <= op_a[arb_idx][7:0];
            shreg_reg      <= {8'h00, op_b[arb_idx], op_a[arb_idx][63:8]};
            mul_enable_reg <= 1'b1;
            load_cnt_reg   <= '0;
            id_reg         <= arb_idx;
            rr_ptr_reg     <= ptr_next;
            state_reg      <= LOAD;
          end
        end
        LOAD: begin
          if (load_cnt_reg == 4'(OPERAND_BYTES - 1)) begin
            mul_enable_reg <= 1'b0;
            tmo_cnt_reg    <= '0;
            state_reg      <= WAIT;
          end else begin
            mul_data_reg <= shreg_reg[7:0];
            shreg_reg    <= {8'h00, shreg_reg[127:8]};
            load_cnt_reg <= load_cnt_reg + 1'b1;
          end
        end
        WAIT: begin
          if (MUL_READY) begin
            res_reg     <= {MUL_RESULT, res_reg[63:8]};
            res_cnt_reg <= 3'd1;
            state_reg   <= COLLECT;
          end else if (tmo_cnt_reg == 6'(TIMEOUT - 1)) begin
            rsp_data_reg  <= QNAN64;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            tmo_pulse_reg <= 1'b1;
            state_reg     <= GAP;
          end else if (tmo_cnt_reg != '1) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        COLLECT: begin
          if (MUL_READY) begin
            res_reg     <= {MUL_RESULT, res_reg[63:8]};
            res_cnt_reg <= res_cnt_reg + 1'b1;
            if (res_cnt_reg == 3'(RESULT_BYTES - 1)) begin
              rsp_data_reg  <= {MUL_RESULT, res_reg[63:8]};
              rsp_err_reg   <= 1'b0;
              rsp_valid_reg <= 1'b1;
              state_reg     <= GAP;
            end
          end
        end
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
